borrow_bypass_subtractor_seq: RTL and testbench
===============================================

// Module: borrow_bypass_subtractor_seq
// PURPOSE
//  Multi-cycle unsigned subtractor. It is the subtract-direction counterpart
//  of the 8-bit carry-bypass adder. It computes diff = a - b - bin one
//  BLOCK-bit slice per cycle, LSB slice first. A slice whose bits all satisfy
//  a==b passes its borrow-in straight to its borrow-out (borrow bypass).
//  The block sits in the arithmetic datapath behind a valid/ready operand
//  stream and drives a valid/ready result stream.
// PARAMETERS
//  WIDTH  8  operand/result width; must be a multiple of BLOCK
//  BLOCK  4  slice width processed per cycle; NB = WIDTH/BLOCK slices
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous active-low reset
//  in_valid   in   1                  operands a/b/bin valid
//  in_ready   out  1                  block accepts operands (IDLE only)
//  a          in   WIDTH              minuend, unsigned
//  b          in   WIDTH              subtrahend, unsigned
//  bin        in   1                  borrow-in
//  out_valid  out  1                  result valid (DONE only)
//  out_ready  in   1                  consumer accepts result
//  diff       out  WIDTH              (a - b - bin) mod 2^WIDTH
//  bout       out  1                  1 iff a < b + bin
//  byp_cnt    out  $clog2(NB+1)       number of slices that bypassed
// BEHAVIOUR
//  Reset: async on rst_n=0.
//   - state=IDLE, slice counter k=0, operand/borrow regs=0.
//   - in_ready=1, out_valid=0, diff=0, bout=0, byp_cnt=0.
//  States: IDLE, CALC, DONE.
//  - IDLE: in_ready=1.
//    - On in_valid & in_ready: latch a, b, bin; clear diff reg and byp_cnt;
//      k=0; go to CALC.
//  - CALC: in_ready=0, out_valid=0. Each cycle process slice k
//    (bits k*BLOCK+BLOCK-1 .. k*BLOCK), using borrow register br
//    (br is loaded with bin at accept).
//    - Per bit: d_i = a_i ^ b_i ^ bo_(i-1); bo_i = (~a_i & b_i) | (~(a_i ^ b_i) & bo_(i-1)).
//    - Slice propagate P = AND over the slice of ~(a_i ^ b_i).
//    - If P=1: slice borrow-out = br, by bypass, and byp_cnt += 1.
//    - Otherwise slice borrow-out = ripple result. Both paths must yield the
//      identical borrow.
//    - Write the slice of the diff reg; br <= slice borrow-out; k <= k+1.
//    - After slice NB-1: bout <= final borrow; go to DONE.
//  - DONE: out_valid=1; diff/bout/byp_cnt are held stable while out_ready=0.
//    - On out_ready=1: go to IDLE.
//    - in_ready rises the cycle after the handshake, never in the same cycle.
//  Timing:
//   - Latency: out_valid asserts exactly NB cycles after the accept edge.
//   - Minimum initiation interval: NB+2 cycles.
//  Outputs diff/bout/byp_cnt are registered. They keep the last result in
//  IDLE until the next accept clears diff/byp_cnt.
//  Boundaries:
//   - in_valid while not in IDLE: ignored, not latched.
//   - a, b, bin changing during CALC: no effect.
//   - a==b with bin=1: diff=all-ones, bout=1, byp_cnt=NB.
//   - Wrap-around is modulo 2^WIDTH.
//   - k wraps only through the transition to DONE; it never exceeds NB-1.
//   - rst_n low mid-CALC or mid-DONE: the operation is discarded and all
//     regs take reset values immediately.
// TESTING
//  1. a=8'h00, b=8'h01, bin=0 -> after 2 cycles out_valid=1, diff=8'hFF,
//     bout=1, byp_cnt=1.
//  2. a=8'h5A, b=8'h5A, bin=1 -> diff=8'hFF, bout=1, byp_cnt=2.
//     Same operands with bin=0 -> diff=8'h00, bout=0, byp_cnt=2.
//  3. a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, byp_cnt=0.
//  4. Result with out_ready=0 for 5 cycles -> out_valid, diff, bout and
//     byp_cnt stay stable; in_ready=0 throughout; a new in_valid is ignored.
//  5. rst_n pulsed low one cycle after accept -> out_valid=0, diff=0,
//     in_ready=1 at once; no result is ever produced for that operation.
//  6. Random sweep, 10k ops, in_valid held high, random out_ready ->
//     every result matches the reference model (a-b-bin) and P-count;
//     the accept-to-out_valid gap is always 2 cycles.

Source files
------------

// File: rtl/borrow_bypass_subtractor_seq.sv
// borrow_bypass_subtractor_seq
// Multi-cycle unsigned subtractor: diff = a - b - bin, one BLOCK-bit slice per
// cycle, LSB slice first. A slice whose minuend and subtrahend bits are all
// equal forwards its borrow-in directly to its borrow-out, and the number of
// such bypassed slices is reported with the result.
// Operands arrive on a valid/ready stream (accepted only in IDLE) and the
// result leaves on a valid/ready stream (offered only in DONE).

module borrow_bypass_subtractor_seq #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic                               bin,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   diff,
    output logic                               bout,
    output logic [$clog2(WIDTH/BLOCK+1)-1:0]   byp_cnt
);

    localparam int NB = WIDTH / BLOCK;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;

    logic [KW-1:0]     k_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              br_r;
    logic [WIDTH-1:0]  diff_r;
    logic              bout_r;
    logic [CW-1:0]     byp_r;
    logic              in_ready_r;
    logic              out_valid_r;

    logic              last_s;
    logic [WIDTH-1:0]  a_sh_s;
    logic [WIDTH-1:0]  b_sh_s;
    logic [BLOCK-1:0]  a_sl_s;
    logic [BLOCK-1:0]  b_sl_s;
    logic [BLOCK-1:0]  sl_d_s;
    logic              chain_s;
    logic              rip_bo_s;
    logic              prop_s;
    logic              sl_bo_s;
    logic [WIDTH-1:0]  diff_nx_s;

    assign last_s = (k_r == KW'(NB - 1));

    // Next-state decode for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Slice k: ripple borrow chain, slice propagate and bypass selection.
    always_comb begin
        a_sh_s   = a_r >> (int'(k_r) * BLOCK);
        b_sh_s   = b_r >> (int'(k_r) * BLOCK);
        a_sl_s   = a_sh_s[BLOCK-1:0];
        b_sl_s   = b_sh_s[BLOCK-1:0];
        sl_d_s   = {BLOCK{1'b0}};
        chain_s  = br_r;
        for (int i = 0; i < BLOCK; i++) begin
            sl_d_s[i] = a_sl_s[i] ^ b_sl_s[i] ^ chain_s;
            chain_s   = (~a_sl_s[i] & b_sl_s[i]) | (~(a_sl_s[i] ^ b_sl_s[i]) & chain_s);
        end
        rip_bo_s = chain_s;
        prop_s   = &(~(a_sl_s ^ b_sl_s));
        // With every bit pair equal the ripple chain just forwards br_r, so
        // both sources agree; the bypass path skips the chain entirely.
        if (prop_s) begin
            sl_bo_s = br_r;
        end else begin
            sl_bo_s = rip_bo_s;
        end
        diff_nx_s = diff_r;
        diff_nx_s[int'(k_r) * BLOCK +: BLOCK] = sl_d_s;
    end

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    // Operand capture, per-slice result write-back and bypass counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r    <= {KW{1'b0}};
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            diff_r <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
            byp_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        br_r   <= bin;
                        diff_r <= {WIDTH{1'b0}};
                        byp_r  <= {CW{1'b0}};
                        k_r    <= {KW{1'b0}};
                    end
                end
                ST_CALC: begin
                    diff_r <= diff_nx_s;
                    br_r   <= sl_bo_s;
                    if (prop_s) begin
                        byp_r <= byp_r + CW'(1);
                    end
                    if (last_s) begin
                        k_r    <= {KW{1'b0}};
                        bout_r <= sl_bo_s;
                    end else begin
                        k_r    <= k_r + KW'(1);
                    end
                end
                ST_DONE: begin
                    k_r <= {KW{1'b0}};
                end
                default: begin
                    k_r <= {KW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign byp_cnt   = byp_r;

endmodule

// File: tb/tb_borrow_bypass_subtractor_seq.sv
// Bench for borrow_bypass_subtractor_seq (WIDTH=8, BLOCK=4, NB=2).
// A transaction-level model tracks outstanding operations and predicts the
// handshake signals and result every cycle; directed vectors additionally
// pin results to hand-computed literals.

module tb_borrow_bypass_subtractor_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic [1:0] byp_cnt;

    int n_chk = 0;
    int n_bad = 0;

    // model state
    bit         m_out = 1'b0;
    int         m_cyc = 0;
    int         m_acc = 0;
    int         m_nacc = 0;
    logic [10:0] m_pend = 11'd0;
    logic [10:0] m_last = 11'd0;

    always #5 clk = ~clk;

    borrow_bypass_subtractor_seq #(.WIDTH(8), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .byp_cnt   (byp_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result packed as {byp_cnt[1:0], bout, diff[7:0]}.
    function automatic logic [10:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int         r;
        logic [7:0] d;
        logic [1:0] cnt;
        logic [3:0] xs;
        logic [3:0] ys;
        r   = int'(x) - int'(y) - int'(bi);
        d   = 8'(r);
        cnt = 2'd0;
        for (int s = 0; s < 2; s++) begin
            xs = x[s*4 +: 4];
            ys = y[s*4 +: 4];
            if (xs == ys) cnt = cnt + 2'd1;
        end
        return {cnt, (r < 0), d};
    endfunction

    // Transaction model: one op in flight, result visible 2 cycles after accept.
    initial begin
        bit ov_prev;
        bit ir_prev;
        forever begin
            @(posedge clk);
            ov_prev = m_out && (m_cyc - m_acc >= 2);
            ir_prev = !m_out;
            m_cyc++;
            if (!rst_n) begin
                m_out  = 1'b0;
                m_last = 11'd0;
            end else if (ov_prev && out_ready) begin
                m_out  = 1'b0;
                m_last = m_pend;
            end else if (ir_prev && in_valid) begin
                m_out  = 1'b1;
                m_acc  = m_cyc;
                m_nacc++;
                m_pend = ref_sub(a, b, bin);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        bit e_ov;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_diff", 32'(diff), 32'd0);
                chk("rst_bout", 32'(bout), 32'd0);
                chk("rst_byp", 32'(byp_cnt), 32'd0);
            end else begin
                e_ov = m_out && (m_cyc - m_acc >= 2);
                chk("in_ready", 32'(in_ready), 32'(!m_out));
                chk("out_valid", 32'(out_valid), 32'(e_ov));
                if (e_ov) begin
                    chk("res_diff", 32'(diff), 32'(m_pend[7:0]));
                    chk("res_bout", 32'(bout), 32'(m_pend[8]));
                    chk("res_byp", 32'(byp_cnt), 32'(m_pend[10:9]));
                end else if (!m_out) begin
                    chk("idle_diff", 32'(diff), 32'(m_last[7:0]));
                    chk("idle_bout", 32'(bout), 32'(m_last[8]));
                    chk("idle_byp", 32'(byp_cnt), 32'(m_last[10:9]));
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                          input logic [7:0] ed, input logic eb, input logic [1:0] ec,
                          input int hold);
        int n;
        bit got;
        @(posedge clk); #2;
        in_valid = 1'b1; a = ta; b = tb; bin = tbi; out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0; a = ~ta; b = 8'($urandom); bin = ~tbi;
        n = 0; got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (out_valid) got = 1'b1;
        end
        chk("lit_latency", 32'(n), 32'd3);
        chk("lit_diff", 32'(diff), 32'(ed));
        chk("lit_bout", 32'(bout), 32'(eb));
        chk("lit_byp", 32'(byp_cnt), 32'(ec));
        if (hold > 0) begin
            in_valid = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                chk("hold_diff", 32'(diff), 32'(ed));
                chk("hold_bout", 32'(bout), 32'(eb));
                chk("hold_byp", 32'(byp_cnt), 32'(ec));
            end
        end
        @(posedge clk); #2;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int base;
        int cyc;
        rst_n = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_diff", 32'(diff), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 2'd1, 0);
        run_op(8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 2'd2, 0);
        run_op(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 2'd2, 0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 2'd0, 5);
        run_op(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 2'd1, 0);
        run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 2'd0, 0);
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 2'd0, 0);

        // reset one cycle after accept discards the operation
        @(posedge clk); #2;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_result", 32'(out_valid), 32'd0);
        end

        // random sweep with in_valid held high
        base = m_nacc;
        cyc = 0;
        @(posedge clk); #2 in_valid = 1'b1;
        while (m_nacc < base + 10000 && cyc < 70000) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bin = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b[3:0] = a[3:0];
            if ($urandom_range(0, 3) == 0) b[7:4] = a[7:4];
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
            cyc++;
        end
        chk("sweep_ops", 32'(m_nacc - base >= 10000), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
